// File: rtl/count_pkg.sv
// Shared definitions for the key-driven two-digit counter: controller
// state encoding and the 7-segment digit table.
`timescale 1ns/1ps
package count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Segment patterns for digits 0..9: [6:0]=g..a, upper bits unused here.
    localparam logic [8:0] SEG_DIGIT [10] = '{
        9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
        9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f
    };

    // Segment bits g..a for a BCD digit; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        code = 7'h00;
        if (digit <= 4'd9) begin
            code = SEG_DIGIT[digit][6:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Count-rate divider. Advances only while enabled, so a pause keeps the
// partially elapsed tick period; tick is high in the last divider cycle.
`timescale 1ns/1ps
module tick_gen #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] divider;

    assign tick = en && (divider == LAST);

    // Divider: clears on request, otherwise counts 0..DIV-1 while enabled and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divider <= '0;
        end else if (clr) begin
            divider <= '0;
        end else if (en) begin
            divider <= tick ? '0 : divider + 1'b1;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear controller for the two-digit display counter. Steps a
// BCD value between 00 and MAX on divider ticks, driven by one-cycle key
// pulses, and decodes both digits onto the segment pins.
`timescale 1ns/1ps
module count_ctrl
    import count_pkg::*;
#(
    parameter int CLK_HZ  = 12_000_000,
    parameter int TICK_HZ = 1,
    parameter int MAX     = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       clear_pulse,
    input  logic       mode_pulse,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [8:0] seg_led_1,
    output logic [8:0] seg_led_2,
    output logic       running,
    output logic       done,
    output logic       dir_down
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] tens_nxt;
    logic [3:0] ones_nxt;
    logic       dir_nxt;
    logic       tick;
    logic       at_term;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state == RUN),
        .clr (clear_pulse),
        .tick(tick)
    );

    // Terminal value depends on direction: MAX counting up, 00 counting down.
    assign at_term = dir_down ? ((tens == 4'd0) && (ones == 4'd0))
                              : ((tens == MAX_T) && (ones == MAX_O));

    // Next state and next counter value; clear overrides everything else.
    always_comb begin
        state_nxt = state;
        tens_nxt  = tens;
        ones_nxt  = ones;
        dir_nxt   = dir_down;
        if (clear_pulse) begin
            state_nxt = IDLE;
            tens_nxt  = dir_down ? MAX_T : 4'd0;
            ones_nxt  = dir_down ? MAX_O : 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode_pulse) begin
                        // Reload from the new direction, i.e. the inverse of the current one.
                        dir_nxt  = ~dir_down;
                        tens_nxt = dir_down ? 4'd0 : MAX_T;
                        ones_nxt = dir_down ? 4'd0 : MAX_O;
                    end
                    if (start_pulse) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (at_term) begin
                            state_nxt = DONE;
                        end else if (dir_down) begin
                            if (ones == 4'd0) begin
                                ones_nxt = 4'd9;
                                tens_nxt = tens - 4'd1;
                            end else begin
                                ones_nxt = ones - 4'd1;
                            end
                        end else begin
                            if (ones == 4'd9) begin
                                ones_nxt = 4'd0;
                                tens_nxt = tens + 4'd1;
                            end else begin
                                ones_nxt = ones + 4'd1;
                            end
                        end
                    end
                    // A start on the final tick loses to DONE; otherwise the tick step still lands.
                    if (start_pulse && !(tick && at_term)) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_pulse) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Controller registers; status flags are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tens     <= 4'd0;
            ones     <= 4'd0;
            dir_down <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tens     <= tens_nxt;
            ones     <= ones_nxt;
            dir_down <= dir_nxt;
            running  <= (state_nxt == RUN);
            done     <= (state_nxt == DONE);
        end
    end

    assign seg_led_1 = {1'b0, done,    seg_code(tens)};
    assign seg_led_2 = {1'b0, running, seg_code(ones)};

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: stimulus pushes the expected output changes (value,
// flags and the cycle they must appear in) into a queue per DUT; monitors
// pop and compare whenever the DUT outputs change.
`timescale 1ns/1ps
module tb_count_ctrl;

    typedef struct {
        int         at;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       dn;
        logic       dd;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst, start_pulse, clear_pulse, mode_pulse;
    logic [3:0] tens, ones;
    logic [8:0] seg_led_1, seg_led_2;
    logic       running, done, dir_down;

    logic       b_rst, b_start, b_clear, b_mode;
    logic [3:0] b_tens, b_ones;
    logic [8:0] b_seg1, b_seg2;
    logic       b_running, b_done, b_dir;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_a = 1'b0;
    logic mon_b = 1'b0;
    logic [10:0] prev_a, prev_b;
    evt_t qa[$];
    evt_t qb[$];

    count_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .MAX(12)) dut_a (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .clear_pulse(clear_pulse),
        .mode_pulse(mode_pulse), .tens(tens), .ones(ones), .seg_led_1(seg_led_1),
        .seg_led_2(seg_led_2), .running(running), .done(done), .dir_down(dir_down)
    );

    count_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .MAX(99)) dut_b (
        .clk(clk), .rst(b_rst), .start_pulse(b_start), .clear_pulse(b_clear),
        .mode_pulse(b_mode), .tens(b_tens), .ones(b_ones), .seg_led_1(b_seg1),
        .seg_led_2(b_seg2), .running(b_running), .done(b_done), .dir_down(b_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] bseg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3f;
            4'd1: return 7'h06;
            4'd2: return 7'h5b;
            4'd3: return 7'h4f;
            4'd4: return 7'h66;
            4'd5: return 7'h6d;
            4'd6: return 7'h7d;
            4'd7: return 7'h07;
            4'd8: return 7'h7f;
            4'd9: return 7'h6f;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [10:0] pk(input evt_t e);
        return {e.t, e.o, e.run, e.dn, e.dd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_a(input int at, input int v, input logic r, input logic dn, input logic dd);
        evt_t e;
        e.at = at; e.t = 4'(v / 10); e.o = 4'(v % 10); e.run = r; e.dn = dn; e.dd = dd;
        qa.push_back(e);
    endtask

    task automatic exp_b(input int at, input int v, input logic r, input logic dn, input logic dd);
        evt_t e;
        e.at = at; e.t = 4'(v / 10); e.o = 4'(v % 10); e.run = r; e.dn = dn; e.dd = dd;
        qb.push_back(e);
    endtask

    // Called at a falling edge; the pulse is sampled on the next rising edge.
    task automatic pulse(input logic st, input logic cl, input logic md);
        start_pulse = st; clear_pulse = cl; mode_pulse = md;
        @(negedge clk);
        start_pulse = 1'b0; clear_pulse = 1'b0; mode_pulse = 1'b0;
    endtask

    task automatic pulse_b_start();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor A: every output change must match the next queued expectation.
    always @(negedge clk) begin : mon_a_blk
        logic [10:0] snap;
        evt_t e;
        snap = {tens, ones, running, done, dir_down};
        if (mon_a && (snap !== prev_a)) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected: got %h at cycle %0d, required no change", snap, cyc);
            end else begin
                e = qa.pop_front();
                check("a_outputs", 32'(snap), 32'(pk(e)));
                if (e.at >= 0) check("a_cycle", cyc, e.at);
                check("a_seg1", 32'(seg_led_1), 32'({1'b0, e.dn, bseg(e.t)}));
                check("a_seg2", 32'(seg_led_2), 32'({1'b0, e.run, bseg(e.o)}));
            end
        end
        prev_a <= snap;
    end

    // Monitor B: same checking for the MAX=99 instance.
    always @(negedge clk) begin : mon_b_blk
        logic [10:0] snap;
        evt_t e;
        snap = {b_tens, b_ones, b_running, b_done, b_dir};
        if (mon_b && (snap !== prev_b)) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected: got %h at cycle %0d, required no change", snap, cyc);
            end else begin
                e = qb.pop_front();
                check("b_outputs", 32'(snap), 32'(pk(e)));
                if (e.at >= 0) check("b_cycle", cyc, e.at);
                check("b_seg1", 32'(b_seg1), 32'({1'b0, e.dn, bseg(e.t)}));
                check("b_seg2", 32'(b_seg2), 32'({1'b0, e.run, bseg(e.o)}));
            end
        end
        prev_b <= snap;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, r, c;
        rst = 1'b0; start_pulse = 1'b0; clear_pulse = 1'b0; mode_pulse = 1'b0;
        b_rst = 1'b0; b_start = 1'b0; b_clear = 1'b0; b_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tens", 32'(tens), 0);
        check("rst_seg1", 32'(seg_led_1), 32'h03f);
        check("rst_running", 32'(running), 0);
        check("rst_dir", 32'(dir_down), 0);
        rst = 1'b1; b_rst = 1'b1;

        // Test 1: idle after reset release.
        repeat (5) @(negedge clk);
        check("idle_tens", 32'(tens), 0);
        check("idle_ones", 32'(ones), 0);
        check("idle_seg1", 32'(seg_led_1), 32'h03f);
        check("idle_seg2", 32'(seg_led_2), 32'h03f);
        check("idle_running", 32'(running), 0);
        check("idle_done", 32'(done), 0);
        mon_a = 1'b1; mon_b = 1'b1;

        // Test 2: count up 00..12 with BCD carry, DONE on 13th tick, starts ignored.
        s = cyc + 1;
        exp_a(s, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) exp_a(s + 10 * k, k, 1, 0, 0);
        exp_a(s + 130, 12, 0, 1, 0);
        pulse(1, 0, 0);
        wait_until(s + 134);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        wait_until(s + 160);
        check("done_tens", 32'(tens), 1);
        check("done_ones", 32'(ones), 2);
        check("done_flag", 32'(done), 1);
        check("t2_drain", qa.size(), 0);
        c = cyc + 1;
        exp_a(c, 0, 0, 0, 0);
        pulse(0, 1, 0);
        repeat (2) @(negedge clk);

        // Test 3: pause at 25 cycles keeps value and divider fraction.
        s = cyc + 1;
        exp_a(s, 0, 1, 0, 0);
        exp_a(s + 10, 1, 1, 0, 0);
        exp_a(s + 20, 2, 1, 0, 0);
        exp_a(s + 25, 2, 0, 0, 0);
        pulse(1, 0, 0);
        wait_until(s + 24);
        pulse(1, 0, 0);
        wait_until(s + 125);
        check("pause_ones", 32'(ones), 2);
        r = cyc + 1;
        exp_a(r, 2, 1, 0, 0);
        exp_a(r + 5, 3, 1, 0, 0);
        pulse(1, 0, 0);
        wait_until(r + 7);
        check("resume_ones", 32'(ones), 3);
        c = cyc + 1;
        exp_a(c, 0, 0, 0, 0);
        pulse(0, 1, 0);
        repeat (2) @(negedge clk);

        // Test 4: mode in IDLE -> down from 12 to 00, DONE; mode in RUN/DONE ignored.
        c = cyc + 1;
        exp_a(c, 12, 0, 0, 1);
        pulse(0, 0, 1);
        repeat (2) @(negedge clk);
        s = cyc + 1;
        exp_a(s, 12, 1, 0, 1);
        for (int k = 1; k <= 12; k++) exp_a(s + 10 * k, 12 - k, 1, 0, 1);
        exp_a(s + 130, 0, 0, 1, 1);
        pulse(1, 0, 0);
        wait_until(s + 14);
        pulse(0, 0, 1);
        wait_until(s + 134);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        wait_until(s + 140);
        check("down_done_ones", 32'(ones), 0);
        check("down_dir", 32'(dir_down), 1);
        c = cyc + 1;
        exp_a(c, 12, 0, 0, 1);
        pulse(0, 1, 0);
        repeat (2) @(negedge clk);
        c = cyc + 1;
        exp_a(c, 0, 0, 0, 0);
        pulse(0, 0, 1);
        repeat (2) @(negedge clk);

        // Test 5: clear and start together at 07 -> IDLE 00.
        s = cyc + 1;
        exp_a(s, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) exp_a(s + 10 * k, k, 1, 0, 0);
        exp_a(s + 75, 0, 0, 0, 0);
        pulse(1, 0, 0);
        wait_until(s + 74);
        pulse(1, 1, 0);
        wait_until(s + 100);
        check("clr_running", 32'(running), 0);
        check("clr_ones", 32'(ones), 0);
        check("t5_drain", qa.size(), 0);

        // Test 6: async reset mid-RUN at 05 on the MAX=99 instance.
        s = cyc + 1;
        exp_b(s, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) exp_b(s + 10 * k, k, 1, 0, 0);
        exp_b(-1, 0, 0, 0, 0);
        pulse_b_start();
        wait_until(s + 55);
        check("b_pre_ones", 32'(b_ones), 5);
        #2 b_rst = 1'b0;
        #1;
        check("b_rst_tens", 32'(b_tens), 0);
        check("b_rst_ones", 32'(b_ones), 0);
        check("b_rst_seg1", 32'(b_seg1), 32'h03f);
        check("b_rst_seg2", 32'(b_seg2), 32'h03f);
        check("b_rst_running", 32'(b_running), 0);
        check("b_rst_done", 32'(b_done), 0);
        check("b_rst_dir", 32'(b_dir), 0);
        @(negedge clk);
        b_rst = 1'b1;
        repeat (2) @(negedge clk);
        s = cyc + 1;
        exp_b(s, 0, 1, 0, 0);
        exp_b(s + 10, 1, 1, 0, 0);
        pulse_b_start();
        wait_until(s + 9);
        check("b_no_early_tick", 32'(b_ones), 0);
        wait_until(s + 12);
        check("b_first_tick", 32'(b_ones), 1);

        check("a_final_drain", qa.size(), 0);
        check("b_final_drain", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
